// File: rtl/tx_frame_arbiter_if.sv
// Byte-stream request channel from one frame requester into the arbiter.
interface tx_req_if;
  logic       valid;
  logic [7:0] data;
  logic       last;
  logic       ready;

  // Requester side drives the byte, the arbiter answers with ready.
  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin frame scheduler feeding the GMII side of a 1000BASE-X PCS
// transmitter: preamble/SFD insertion, short-frame padding, inter-packet
// gap and underrun abort with drain of the rest of the requester's frame.
module tx_frame_arbiter #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IPG_LEN      = 12,
  parameter int unsigned MIN_PAYLOAD  = 60
) (
  input  logic        GTX_CLK,
  input  logic        RESET,
  tx_req_if.slave     req_a,
  tx_req_if.slave     req_b,
  output logic        TX_EN,
  output logic [7:0]  tx_octet,
  output logic [1:0]  grant,
  output logic        tx_underrun
);

  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > IPG_LEN) ? PREAMBLE_LEN : IPG_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PAY_W   = $clog2(MIN_PAYLOAD + 1);

  localparam logic [7:0] OCT_PRE = 8'h55;
  localparam logic [7:0] OCT_SFD = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_DROP,
    S_IPG
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_b_q, last_b_d;       // 1: B was served last
  logic [CNT_W-1:0]   cnt_q, cnt_d;             // preamble / IPG octet counter
  logic [PAY_W-1:0]   pay_q, pay_d;             // payload octets, saturating
  logic               last_acc_q, last_acc_d;   // last byte of frame taken
  logic               tx_en_q, tx_en_d;
  logic [7:0]         octet_q, octet_d;
  logic               underrun_q, underrun_d;

  logic               g_valid_c;
  logic [7:0]         g_data_c;
  logic               g_last_c;
  logic               rdy_c;
  logic               any_req_c;
  logic               pick_b_c;
  logic               go_start_c;
  logic               go_ipg_c;

  // Granted requester's channel and ready generation (combinational from state).
  always_comb begin
    g_valid_c = grant_q[1] ? req_b.valid : req_a.valid;
    g_data_c  = grant_q[1] ? req_b.data  : req_a.data;
    g_last_c  = grant_q[1] ? req_b.last  : req_a.last;
    rdy_c     = (((state_q == S_SFD) || (state_q == S_DATA)) && !last_acc_q) ||
                (state_q == S_DROP);
    any_req_c = req_a.valid || req_b.valid;
    pick_b_c  = req_b.valid && (!req_a.valid || !last_b_q);
  end

  assign req_a.ready = rdy_c && grant_q[0];
  assign req_b.ready = rdy_c && grant_q[1];

  // Next-state, counters and the octet to present on the next cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_b_d   = last_b_q;
    cnt_d      = cnt_q;
    pay_d      = pay_q;
    last_acc_d = last_acc_q;
    tx_en_d    = 1'b0;
    octet_d    = 8'h00;
    underrun_d = 1'b0;
    go_start_c = 1'b0;
    go_ipg_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        go_start_c = any_req_c;
      end
      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
          state_d = S_SFD;
          octet_d = OCT_SFD;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          octet_d = OCT_PRE;
        end
      end
      S_SFD, S_DATA: begin
        if (rdy_c) begin
          if (g_valid_c) begin
            state_d    = S_DATA;
            tx_en_d    = 1'b1;
            octet_d    = g_data_c;
            last_acc_d = g_last_c;
            if (pay_q != PAY_W'(MIN_PAYLOAD)) begin
              pay_d = pay_q + PAY_W'(1);
            end
          end else begin
            state_d    = S_DROP;
            underrun_d = 1'b1;
          end
        end else if (pay_q < PAY_W'(MIN_PAYLOAD)) begin
          state_d = S_PAD;
          tx_en_d = 1'b1;
          pay_d   = pay_q + PAY_W'(1);
        end else begin
          go_ipg_c = 1'b1;
        end
      end
      S_PAD: begin
        if (pay_q < PAY_W'(MIN_PAYLOAD)) begin
          tx_en_d = 1'b1;
          pay_d   = pay_q + PAY_W'(1);
        end else begin
          go_ipg_c = 1'b1;
        end
      end
      S_DROP: begin
        go_ipg_c = g_valid_c && g_last_c;
      end
      S_IPG: begin
        if (cnt_q == CNT_W'(IPG_LEN - 1)) begin
          if (any_req_c) begin
            go_start_c = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase

    // Frame finished (clean or aborted): record who was served, open the gap.
    if (go_ipg_c) begin
      state_d  = S_IPG;
      cnt_d    = '0;
      last_b_d = grant_q[1];
    end

    // New winner: load grant and emit the first preamble octet next cycle.
    if (go_start_c) begin
      state_d    = S_PREAMBLE;
      grant_d    = pick_b_c ? 2'b10 : 2'b01;
      cnt_d      = '0;
      pay_d      = '0;
      last_acc_d = 1'b0;
      tx_en_d    = 1'b1;
      octet_d    = OCT_PRE;
    end
  end

  // State and output registers; reset parks the block idle with A priority.
  always_ff @(posedge GTX_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      grant_q    <= 2'b00;
      last_b_q   <= 1'b1;
      cnt_q      <= '0;
      pay_q      <= '0;
      last_acc_q <= 1'b0;
      tx_en_q    <= 1'b0;
      octet_q    <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_b_q   <= last_b_d;
      cnt_q      <= cnt_d;
      pay_q      <= pay_d;
      last_acc_q <= last_acc_d;
      tx_en_q    <= tx_en_d;
      octet_q    <= octet_d;
      underrun_q <= underrun_d;
    end
  end

  assign TX_EN       = tx_en_q;
  assign tx_octet    = octet_q;
  assign grant       = grant_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: default-parameter instance plus a
// minimal-parameter instance (1/1/1) for the back-to-back one-byte case.
module tb_tx_frame_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_req_if a_if ();
  tx_req_if b_if ();
  tx_req_if c_if ();
  tx_req_if d_if ();

  logic       tx_en, tx_und;
  logic [7:0] tx_oct;
  logic [1:0] gnt;
  logic       tx_en_s, tx_und_s;
  logic [7:0] tx_oct_s;
  logic [1:0] gnt_s;

  tx_frame_arbiter u_dut (
    .GTX_CLK     (clk),
    .RESET       (rst),
    .req_a       (a_if),
    .req_b       (b_if),
    .TX_EN       (tx_en),
    .tx_octet    (tx_oct),
    .grant       (gnt),
    .tx_underrun (tx_und)
  );

  tx_frame_arbiter #(.PREAMBLE_LEN(1), .IPG_LEN(1), .MIN_PAYLOAD(1)) u_small (
    .GTX_CLK     (clk),
    .RESET       (rst),
    .req_a       (c_if),
    .req_b       (d_if),
    .TX_EN       (tx_en_s),
    .tx_octet    (tx_oct_s),
    .grant       (gnt_s),
    .tx_underrun (tx_und_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester sources: 0 = A, 1 = B (big instance), 2 = A of small instance.
  int         s_len[3];
  int         s_idx[3];
  int         s_frames[3];
  int         s_stall_at[3];
  int         s_stall_left[3];
  logic [7:0] s_base[3];

  // Per-cycle output log, sampled 1 time unit after each rising edge.
  logic       log_en[1024];
  logic [7:0] log_oct[1024];
  logic [1:0] log_gnt[1024];
  logic       log_und[1024];
  logic       log_ardy[1024];
  logic       log_brdy[1024];
  logic       log_en_s[1024];
  logic [7:0] log_oct_s[1024];
  logic [1:0] log_gnt_s[1024];
  logic       log_und_s[1024];
  int         log_n;

  int r_start[8];
  int r_len[8];
  logic [1:0] r_gnt[8];
  int nr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic       v[3];
    logic [7:0] d[3];
    logic       l[3];
    for (int i = 0; i < 3; i++) begin
      logic stalled;
      stalled = (s_frames[i] > 0) && (s_idx[i] == s_stall_at[i]) && (s_stall_left[i] > 0);
      if (stalled) s_stall_left[i]--;
      v[i] = (s_frames[i] > 0) && !stalled;
      d[i] = s_base[i] + 8'(s_idx[i]);
      l[i] = (s_idx[i] == s_len[i] - 1);
    end
    a_if.valid = v[0]; a_if.data = d[0]; a_if.last = l[0];
    b_if.valid = v[1]; b_if.data = d[1]; b_if.last = l[1];
    c_if.valid = v[2]; c_if.data = d[2]; c_if.last = l[2];
  endtask

  task automatic clear_sources();
    for (int i = 0; i < 3; i++) begin
      s_len[i] = 1; s_idx[i] = 0; s_frames[i] = 0;
      s_stall_at[i] = -1; s_stall_left[i] = 0; s_base[i] = 8'h00;
    end
    drive();
  endtask

  task automatic step();
    logic acc[3];
    acc[0] = a_if.valid && a_if.ready;
    acc[1] = b_if.valid && b_if.ready;
    acc[2] = c_if.valid && c_if.ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        if (s_idx[i] == s_len[i] - 1) begin
          s_idx[i] = 0;
          s_frames[i]--;
        end else begin
          s_idx[i]++;
        end
      end
    end
    drive();
    if (log_n < 1024) begin
      log_en[log_n]   = tx_en;   log_oct[log_n]   = tx_oct;
      log_gnt[log_n]  = gnt;     log_und[log_n]   = tx_und;
      log_ardy[log_n] = a_if.ready; log_brdy[log_n] = b_if.ready;
      log_en_s[log_n] = tx_en_s; log_oct_s[log_n] = tx_oct_s;
      log_gnt_s[log_n] = gnt_s;  log_und_s[log_n] = tx_und_s;
      log_n++;
    end
  endtask

  task automatic run(input int n);
    log_n = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    clear_sources();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Extract TX_EN high runs of the big instance from the log.
  task automatic scan_runs();
    nr = 0;
    for (int k = 0; k < log_n; k++) begin
      if (log_en[k] && (k == 0 || !log_en[k-1]) && nr < 8) begin
        r_start[nr] = k; r_len[nr] = 0; r_gnt[nr] = log_gnt[k]; nr++;
      end
      if (log_en[k] && nr > 0) r_len[nr-1]++;
    end
  endtask

  initial begin
    int cnt;
    int found;
    logic [1:0] g_exp[4];
    logic [7:0] f_exp[4];
    logic [7:0] pat[4];

    rst = 1'b1;
    clear_sources();
    d_if.valid = 1'b0; d_if.data = 8'h00; d_if.last = 1'b0;
    #1;
    // Reset state (asynchronous, before any clock edge)
    check("rst_tx_en", tx_en, 0);
    check("rst_octet", tx_oct, 8'h00);
    check("rst_grant", gnt, 2'b00);
    check("rst_a_ready", a_if.ready, 0);
    check("rst_b_ready", b_if.ready, 0);
    check("rst_underrun", tx_und, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // A: 64-byte frame 0x01..0x40, B idle
    s_len[0] = 64; s_frames[0] = 1; s_base[0] = 8'h01; drive();
    run(100);
    scan_runs();
    check("t64_runs", nr, 1);
    check("t64_start", r_start[0], 0);
    check("t64_len", r_len[0], 72);
    check("t64_grant", r_gnt[0], 2'b01);
    cnt = 0; for (int k = 0; k < 7; k++) if (log_oct[k] === 8'h55) cnt++;
    check("t64_preamble", cnt, 7);
    check("t64_sfd", log_oct[7], 8'hD5);
    cnt = 0; for (int k = 0; k < 64; k++) if (log_oct[8+k] !== 8'(k + 1)) cnt++;
    check("t64_payload_errs", cnt, 0);
    cnt = 0; for (int k = 72; k < 84; k++) if (log_en[k] === 1'b0) cnt++;
    check("t64_ipg_low", cnt, 12);
    check("t64_grant_clear", log_gnt[90], 2'b00);

    // A: 10-byte frame, padded to 60
    s_len[0] = 10; s_frames[0] = 1; s_base[0] = 8'h01; drive();
    run(90);
    scan_runs();
    check("t10_len", r_len[0], 68);
    cnt = 0; for (int k = 0; k < 10; k++) if (log_oct[8+k] !== 8'(k + 1)) cnt++;
    check("t10_payload_errs", cnt, 0);
    cnt = 0; for (int k = 18; k < 68; k++) if (log_oct[k] !== 8'h00 || log_en[k] !== 1'b1) cnt++;
    check("t10_pad_errs", cnt, 0);

    // A and B both continuously valid: alternate A,B,A,B with 12-cycle gaps
    do_reset();
    s_len[0] = 64; s_frames[0] = 2; s_base[0] = 8'h01;
    s_len[1] = 64; s_frames[1] = 2; s_base[1] = 8'h81; drive();
    run(360);
    scan_runs();
    g_exp[0] = 2'b01; g_exp[1] = 2'b10; g_exp[2] = 2'b01; g_exp[3] = 2'b10;
    f_exp[0] = 8'h01; f_exp[1] = 8'h81; f_exp[2] = 8'h01; f_exp[3] = 8'h81;
    check("rr_runs", nr, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_grant%0d", k), r_gnt[k], g_exp[k]);
      check($sformatf("rr_len%0d", k), r_len[k], 72);
      check($sformatf("rr_first%0d", k), log_oct[r_start[k] + 8], f_exp[k]);
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("rr_gap%0d", k), r_start[k+1] - (r_start[k] + r_len[k]), 12);

    // Underrun: A stalls after byte 5, then drains; B waits and follows
    do_reset();
    s_len[0] = 64; s_frames[0] = 1; s_base[0] = 8'h01;
    s_stall_at[0] = 5; s_stall_left[0] = 3;
    s_len[1] = 64; s_frames[1] = 1; s_base[1] = 8'h81; drive();
    run(200);
    scan_runs();
    check("ur_runs", nr, 2);
    check("ur_len_a", r_len[0], 13);
    check("ur_grant_a", r_gnt[0], 2'b01);
    check("ur_last_byte", log_oct[12], 8'h05);
    cnt = 0; for (int k = 0; k < log_n; k++) if (log_und[k] === 1'b1) cnt++;
    check("ur_pulses", cnt, 1);
    check("ur_pulse_cycle", log_und[13], 1);
    check("ur_drop_a_ready", log_ardy[14], 1);
    check("ur_drop_b_ready", log_brdy[14], 0);
    check("ur_a_drained", s_frames[0], 0);
    check("ur_start_b", r_start[1], 86);
    check("ur_grant_b", r_gnt[1], 2'b10);
    check("ur_len_b", r_len[1], 72);
    check("ur_first_b", log_oct[r_start[1] + 8], 8'h81);

    // Reset during byte 30, then fresh frame right after release
    do_reset();
    s_len[0] = 64; s_frames[0] = 1; s_base[0] = 8'h01; drive();
    log_n = 0; found = -1;
    for (int k = 0; k < 100 && found < 0; k++) begin
      step();
      if (log_en[log_n-1] === 1'b1 && log_oct[log_n-1] === 8'h1E) found = log_n - 1;
    end
    check("mr_byte30_cycle", found, 37);
    #2 rst = 1'b1;
    #1;
    check("mr_tx_en_async", tx_en, 0);
    check("mr_grant_async", gnt, 2'b00);
    check("mr_a_ready_async", a_if.ready, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    s_idx[0] = 0; s_frames[0] = 1; drive();
    run(90);
    check("mr_restart_en", log_en[0], 1);
    check("mr_restart_oct", log_oct[0], 8'h55);
    check("mr_restart_grant", log_gnt[0], 2'b01);
    scan_runs();
    check("mr_restart_len", r_len[0], 72);

    // Minimal parameters: 0x55, 0xD5, data, one idle cycle, repeat
    s_len[2] = 1; s_frames[2] = 3; s_base[2] = 8'h3C; drive();
    run(16);
    pat[0] = 8'h55; pat[1] = 8'hD5; pat[2] = 8'h3C; pat[3] = 8'h00;
    cnt = 0; for (int k = 0; k < 12; k++) if (log_en_s[k] !== ((k % 4) != 3)) cnt++;
    check("min_en_errs", cnt, 0);
    cnt = 0; for (int k = 0; k < 12; k++) if (log_oct_s[k] !== pat[k % 4]) cnt++;
    check("min_oct_errs", cnt, 0);
    check("min_grant", log_gnt_s[0], 2'b01);
    cnt = 0; for (int k = 12; k < 16; k++) if (log_en_s[k] === 1'b0) cnt++;
    check("min_idle_after", cnt, 4);
    cnt = 0; for (int k = 0; k < 16; k++) if (log_und_s[k] === 1'b1) cnt++;
    check("min_no_underrun", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
